cla_adder_seq: RTL and testbench
================================

// Module: cla_adder_seq
// PURPOSE
//  Parametrised, multi-cycle carry-lookahead adder/subtractor. Operands of WIDTH bits are split into 4-bit
//  lookahead groups. A second lookahead level spans the groups. Add or subtract is selected per operation.
//  A start/busy/done handshake connects it to a controlling FSM or testbench driver.
//  Results are registered and held until the next operation completes.
// PARAMETERS
//  WIDTH   16  operand/result width; multiple of 4, range 4..64 (checked at elaboration)
//  NG      WIDTH/4  derived localparam: number of 4-bit lookahead groups
// PORTS
//  clk     in   1      single clock, rising edge
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled high while ready -> operation accepted
//  sub     in   1      0: A+B+cin   1: A-B (B inverted, carry-in forced 1, cin ignored)
//  cin     in   1      carry-in for add mode
//  a       in   WIDTH  operand A, captured on accept
//  b       in   WIDTH  operand B, captured on accept
//  busy    out  1      operation in flight (states PG, CARRY, SUM)
//  done    out  1      one-cycle pulse: sum/cout/ovf updated this cycle
//  sum     out  WIDTH  result, held between operations
//  cout    out  1      carry out of MSB (subtract: 1 = no borrow)
//  ovf     out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  Reset: state=IDLE. busy, done, sum, cout, ovf and all internal regs = 0.
//   rst_n low mid-operation aborts immediately: no done pulse, and outputs return to 0.
//  FSM: IDLE -> PG -> CARRY -> SUM -> DONE -> IDLE.
//   ready = (state==IDLE || state==DONE).
//  Accept: edge where start=1 and ready=1 -> capture a, b^{WIDTH{sub}}, c0=sub?1:cin; next state PG.
//   start while busy is ignored, with no queueing and no error.
//   start held high re-triggers on every ready cycle; this is level-sensitive, with no edge detect.
//  PG    : register p=a^b', g=a&b' (WIDTH bits each).
//  CARRY : per group i: Gi = g3|p3g2|p3p2g1|p3p2p1g0, Pi = &p[4i+3:4i].
//   Group carries C[i+1] = Gi | Pi&C[i], with C[0]=c0, unrolled as full lookahead (no ripple).
//   Register C[NG:0].
//  SUM   : in-group carries are computed from C[i] and p/g.
//   Register sum=p^c[WIDTH-1:0], cout=C[NG], ovf=c[WIDTH-1]^C[NG].
//  DONE  : done=1 for exactly one cycle. A start accepted here goes straight to PG, giving back-to-back throughput.
//  Latency: start accepted at edge k -> done high in the cycle after edge k+3 (4 cycles).
//   Sustained throughput is 1 result per 4 cycles.
//  Width rules: all arithmetic is modulo 2^WIDTH; the carry out appears only on cout.
//   a/b changes after accept have no effect on the result in flight.
//  Outputs are only updated at SUM->DONE; they are stable at all other times.
// STRUCTURE
//  Package cla_pkg: state enum (IDLE, PG, CARRY, SUM, DONE), GROUP_W=4, and function cla_group_pg().
//  Sub-module cla4_group: 4-bit lookahead cell.
//   In: p[3:0], g[3:0], ci.  Out: c[3:0] internal carries, gp, gg group propagate/generate.
//   Instantiated NG times via generate. The top-level second-level lookahead stays in cla_adder_seq.
// TESTING (WIDTH=16 unless noted)
//  1 add carry chain: a=FFFF b=0001 cin=0 sub=0 -> done @ +4, sum=0000, cout=1, ovf=0.
//  2 subtract: a=0005 b=0007 sub=1 -> sum=FFFE, cout=0, ovf=0.
//    a=8000 b=0001 sub=1 -> sum=7FFF, cout=1, ovf=1.
//  3 signed overflow / cin: a=7FFF b=0000 cin=1 -> sum=8000, cout=0, ovf=1.
//  4 handshake: start again during PG with a=1111 -> ignored.
//    start held through DONE -> second op accepted; done pulses 4 cycles apart.
//  5 reset mid-op: rst_n low in CARRY -> busy/done/sum/cout/ovf=0 at once; no done pulse after release.
//  6 random: 10k ops at WIDTH=4, 16 and 64 against the golden model {cout,sum}=a+(sub?~b:b)+(sub?1:cin).

Source files
------------

// File: rtl/cla_pkg.sv
// Shared definitions for the multi-cycle carry-lookahead adder.
//   state_t      : operation sequencing states
//   GROUP_W      : width of one first-level lookahead group
//   cla_group_pg : group propagate/generate of one 4-bit group
package cla_pkg;

    localparam int GROUP_W = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PG    = 3'd1,
        CARRY = 3'd2,
        SUM   = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Returns {gg, gp} for one 4-bit group.
    function automatic logic [1:0] cla_group_pg(input logic [3:0] p, input logic [3:0] g);
        logic gp;
        logic gg;
        gp = &p;
        gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        return {gg, gp};
    endfunction

endpackage

// File: rtl/cla4_group.sv
// 4-bit carry-lookahead cell.
//   p, g : bit propagate / generate of the group
//   ci   : carry into the group
//   c    : carry into each bit of the group (c[0] = ci)
//   gp   : group propagate
//   gg   : group generate
module cla4_group
    import cla_pkg::*;
(
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       ci,
    output logic [3:0] c,
    output logic       gp,
    output logic       gg
);

    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign {gg, gp} = cla_group_pg(p, g);

endmodule

// File: rtl/cla_adder_seq.sv
// Multi-cycle two-level carry-lookahead adder/subtractor with start/busy/done handshake.
//   clk, rst_n    : clock, asynchronous active-low reset
//   start         : operation request, accepted while idle or in the done cycle
//   sub, cin      : subtract select, carry-in (add mode only)
//   a, b          : operands, captured on accept
//   busy          : operation in flight
//   done          : one-cycle pulse when sum/cout/ovf are updated
//   sum, cout, ovf: registered result, held until the next completion
//
// state | meaning
// ------+--------------------------------------------------
// IDLE  | waiting for start
// PG    | bit propagate/generate registered from captured operands
// CARRY | group carries C[NG:0] resolved by second-level lookahead
// SUM   | in-group carries formed, result registered
// DONE  | done pulse; may accept a new operation directly
module cla_adder_seq
    import cla_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / GROUP_W;

    generate
        if ((WIDTH % GROUP_W) != 0 || WIDTH < 4 || WIDTH > 64) begin : g_width_check
            $error("cla_adder_seq: WIDTH must be a multiple of 4 in 4..64");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             c0;
    logic [WIDTH-1:0] p_r;
    logic [WIDTH-1:0] g_r;
    logic [NG:0]      c_grp;

    logic [WIDTH-1:0] c_bit;
    logic [NG-1:0]    grp_p;
    logic [NG-1:0]    grp_g;
    logic [NG:0]      c_next;
    logic             term;
    logic             prop;

    genvar gi;
    generate
        for (gi = 0; gi < NG; gi++) begin : g_grp
            cla4_group u_grp (
                .p  (p_r[GROUP_W*gi +: GROUP_W]),
                .g  (g_r[GROUP_W*gi +: GROUP_W]),
                .ci (c_grp[gi]),
                .c  (c_bit[GROUP_W*gi +: GROUP_W]),
                .gp (grp_p[gi]),
                .gg (grp_g[gi])
            );
        end
    endgenerate

    // Second-level lookahead: each group carry is a flat sum of products over
    // all lower groups and c0, so no carry passes through another group carry.
    always_comb begin
        c_next    = '0;
        term      = 1'b0;
        prop      = 1'b0;
        c_next[0] = c0;
        for (int i = 0; i < NG; i++) begin
            term = grp_g[i];
            prop = grp_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                term = term | (prop & grp_g[j]);
                prop = prop & grp_p[j];
            end
            c_next[i+1] = term | (prop & c0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            c0    <= 1'b0;
            p_r   <= '0;
            g_r   <= '0;
            c_grp <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b ^ {WIDTH{sub}};
                        c0    <= sub | cin;
                        busy  <= 1'b1;
                        state <= PG;
                    end else begin
                        state <= IDLE;
                    end
                end
                PG: begin
                    p_r   <= op_a ^ op_b;
                    g_r   <= op_a & op_b;
                    state <= CARRY;
                end
                CARRY: begin
                    c_grp <= c_next;
                    state <= SUM;
                end
                SUM: begin
                    sum   <= p_r ^ c_bit;
                    cout  <= c_grp[NG];
                    ovf   <= c_bit[WIDTH-1] ^ c_grp[NG];
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cla_adder_seq.sv
// Scoreboard bench for cla_adder_seq: three instances (WIDTH 4, 16, 64) share
// one stimulus stream; directed vectors carry hand-computed 16-bit results,
// random vectors are scored against an arithmetic reference model.
module tb_cla_adder_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic        cin   = 1'b0;
    logic [63:0] a     = '0;
    logic [63:0] b     = '0;

    logic        busy4, done4, cout4, ovf4;
    logic [3:0]  sum4;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;
    logic        busy64, done64, cout64, ovf64;
    logic [63:0] sum64;

    cla_adder_seq #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a[3:0]), .b(b[3:0]), .busy(busy4), .done(done4),
        .sum(sum4), .cout(cout4), .ovf(ovf4)
    );

    cla_adder_seq #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a[15:0]), .b(b[15:0]), .busy(busy16), .done(done16),
        .sum(sum16), .cout(cout16), .ovf(ovf16)
    );

    cla_adder_seq #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin),
        .a(a), .b(b), .busy(busy64), .done(done64),
        .sum(sum64), .cout(cout64), .ovf(ovf64)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q16[$];
    exp_t q64[$];

    // {cout,sum} = a + (sub ? ~b : b) + (sub ? 1 : cin), modulo 2^w; overflow
    // when both addends share a sign that the result does not.
    function automatic exp_t model(input int w, input logic [63:0] ia, input logic [63:0] ib,
                                   input logic isub, input logic icin, input int c);
        logic [64:0] mask, av, bv, full;
        exp_t e;
        mask  = (65'd1 << w) - 65'd1;
        av    = {1'b0, ia} & mask;
        bv    = {1'b0, (isub ? ~ib : ib)} & mask;
        full  = av + bv + {64'd0, (isub | icin)};
        e.sum = full[63:0] & mask[63:0];
        e.cout = full[w];
        e.ovf  = (av[w-1] == bv[w-1]) && (full[w-1] != av[w-1]);
        e.cyc  = c;
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input logic [63:0] s,
                       input logic co, input logic ov);
        check({tag, " sum"}, s, e.sum);
        check({tag, " cout"}, {63'd0, co}, {63'd0, e.cout});
        check({tag, " ovf"}, {63'd0, ov}, {63'd0, e.ovf});
        check({tag, " latency"}, 64'(cyc), 64'(e.cyc + 4));
    endtask

    task automatic unexpected(input string tag);
        total++;
        bad++;
        $display("FAIL %s unexpected done: got done=1 expected no pending op", tag);
    endtask

    always @(negedge clk) begin
        if (rst_n && done4) begin
            if (q4.size() == 0) unexpected("w4");
            else cmp("w4", q4.pop_front(), {60'd0, sum4}, cout4, ovf4);
        end
    end

    always @(negedge clk) begin
        if (rst_n && done16) begin
            if (q16.size() == 0) unexpected("w16");
            else cmp("w16", q16.pop_front(), {48'd0, sum16}, cout16, ovf16);
        end
    end

    always @(negedge clk) begin
        if (rst_n && done64) begin
            if (q64.size() == 0) unexpected("w64");
            else cmp("w64", q64.pop_front(), sum64, cout64, ovf64);
        end
    end

    // Outputs must hold their last completed value except in a done cycle.
    logic [17:0] last16 = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            last16 = '0;
        end else if (done16) begin
            last16 = {sum16, cout16, ovf16};
        end else begin
            check("w16 hold", {46'd0, sum16, cout16, ovf16}, {46'd0, last16});
        end
    end

    task automatic issue(input logic [63:0] ia, input logic [63:0] ib, input logic isub,
                         input logic icin, input bit use_exp, input logic [15:0] es,
                         input logic ec, input logic eo);
        int   n;
        bit   acc;
        exp_t e;
        n   = 0;
        acc = 0;
        while (!acc) begin
            @(negedge clk);
            a     = ia;
            b     = ib;
            sub   = isub;
            cin   = icin;
            start = 1'b1;
            if (!busy16) begin
                acc = 1;
                q4.push_back(model(4, ia, ib, isub, icin, cyc));
                q64.push_back(model(64, ia, ib, isub, icin, cyc));
                if (use_exp) begin
                    e.sum  = {48'd0, es};
                    e.cout = ec;
                    e.ovf  = eo;
                    e.cyc  = cyc;
                    q16.push_back(e);
                end else begin
                    q16.push_back(model(16, ia, ib, isub, icin, cyc));
                end
            end
            n++;
            if (!acc && n > 20) begin
                total++;
                bad++;
                $display("FAIL accept timeout: got busy=1 for %0d cycles expected ready", n);
                acc = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        start = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ra, rb;
        int          mode;

        repeat (3) @(negedge clk);
        check("reset busy", {63'd0, busy16}, 64'd0);
        check("reset done", {63'd0, done16}, 64'd0);
        check("reset sum", {48'd0, sum16}, 64'd0);
        check("reset cout", {63'd0, cout16}, 64'd0);
        check("reset ovf", {63'd0, ovf16}, 64'd0);
        rst_n = 1'b1;

        // directed vectors with hand-computed 16-bit results
        issue(64'hFFFF, 64'h0001, 1'b0, 1'b0, 1, 16'h0000, 1'b1, 1'b0); idle(6);
        issue(64'h0005, 64'h0007, 1'b1, 1'b0, 1, 16'hFFFE, 1'b0, 1'b0); idle(6);
        issue(64'h8000, 64'h0001, 1'b1, 1'b0, 1, 16'h7FFF, 1'b1, 1'b1); idle(6);
        issue(64'h7FFF, 64'h0000, 1'b0, 1'b1, 1, 16'h8000, 1'b0, 1'b1); idle(6);
        issue(64'h0005, 64'h0007, 1'b1, 1'b1, 1, 16'hFFFE, 1'b0, 1'b0); idle(6);

        // start during PG is ignored
        issue(64'h1234, 64'h1111, 1'b0, 1'b0, 1, 16'h2345, 1'b0, 1'b0);
        @(negedge clk);
        a = 64'h1111; b = 64'h1111; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);

        // start held: back-to-back acceptance in the done cycle
        issue(64'h0001, 64'h0002, 1'b0, 1'b0, 1, 16'h0003, 1'b0, 1'b0);
        issue(64'hFFFF, 64'hFFFF, 1'b0, 1'b1, 1, 16'hFFFF, 1'b1, 1'b0);
        issue(64'h4000, 64'h4000, 1'b0, 1'b0, 1, 16'h8000, 1'b0, 1'b1);
        idle(6);

        // reset in CARRY aborts with no done
        issue(64'h00FF, 64'h0F00, 1'b0, 1'b0, 1, 16'h0FFF, 1'b0, 1'b0); idle(6);
        issue(64'h1111, 64'h2222, 1'b0, 1'b0, 1, 16'h3333, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy", {63'd0, busy16}, 64'd0);
        check("abort done", {63'd0, done16}, 64'd0);
        check("abort sum", {48'd0, sum16}, 64'd0);
        check("abort cout", {63'd0, cout16}, 64'd0);
        check("abort ovf", {63'd0, ovf16}, 64'd0);
        q4.delete();
        q16.delete();
        q64.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("post-abort busy", {63'd0, busy16}, 64'd0);

        // random traffic, mostly back-to-back
        for (int i = 0; i < 10000; i++) begin
            mode = $urandom_range(0, 7);
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            if (mode == 0) ra = '1;
            if (mode == 1) rb = '0;
            if (mode == 2) rb = 64'd1;
            issue(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 16'h0, 1'b0, 1'b0);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(10);

        check("w4 queue drained", 64'(q4.size()), 64'd0);
        check("w16 queue drained", 64'(q16.size()), 64'd0);
        check("w64 queue drained", 64'(q64.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
